// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Definitions shared by the 8-bit LFSR traffic generator and the
//   traffic_checker: successor function, lockup value and checker states.
package traffic_pkg;

    // Feedback taps at bits 7,3,2,1 (XNOR form).
    localparam logic [7:0] LFSR_TAPS   = 8'b1000_1110;
    // XNOR lockup value: the successor of 0xFF is 0xFF, so it never appears
    // in a legal stream.
    localparam logic [7:0] LFSR_LOCKUP = 8'hFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
        return {x[6:0], ~(^(x & LFSR_TAPS))};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   inc    : count up by one (holds at all-ones)
//   clr    : synchronous clear, wins over inc
//   count  : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_checker.sv
// traffic_checker
//   Self-synchronising checker for the 8-bit XNOR LFSR byte stream. Every
//   sampled byte must be the successor of the previously sampled one.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   data_in    : received byte, sampled when valid_in=1
//   valid_in   : word strobe, always accepted
//   clr_cnt    : synchronous clear of both counters (FSM unaffected)
//   locked     : checker is in LOCKED
//   err_pulse  : one cycle per mispredicted word while LOCKED
//   word_count : valid words received, saturating
//   err_count  : mispredicted words while LOCKED, saturating
module traffic_checker
    import traffic_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_TH   = LOCK_CNT[3:0];
    localparam logic [3:0] UNLOCK_TH = UNLOCK_CNT[3:0];

    state_t     state_q, state_d;
    logic [7:0] ref_q, ref_d;
    logic [3:0] good_q, good_d;
    logic [3:0] bad_q, bad_d;
    logic       err_pulse_q, err_pulse_d;

    logic [7:0] pred;
    logic       is_lockup;
    logic       match;
    logic [3:0] good_inc;
    logic [3:0] bad_inc;

    assign pred      = lfsr8_next(ref_q);
    assign is_lockup = (data_in == LFSR_LOCKUP);
    assign match     = (data_in == pred) && !is_lockup;
    assign good_inc  = good_q + 4'd1;
    assign bad_inc   = bad_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        if (valid_in) begin
            case (state_q)
                HUNT: begin
                    if (!is_lockup) begin
                        ref_d   = data_in;
                        good_d  = 4'd0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (match) begin
                        ref_d  = data_in;
                        good_d = good_inc;
                        if (good_inc == LOCK_TH) begin
                            state_d = LOCKED;
                            bad_d   = 4'd0;
                        end
                    end else if (!is_lockup) begin
                        // Reseed from the mispredicted word and start counting again.
                        ref_d  = data_in;
                        good_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Always resync to the received byte so one corrupted word
                    // is charged at most twice (itself and its successor).
                    ref_d = data_in;
                    if (match) begin
                        bad_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        bad_d       = bad_inc;
                        if (bad_inc == UNLOCK_TH) begin
                            state_d = is_lockup ? HUNT : SYNC;
                            good_d  = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            ref_q       <= 8'h00;
            good_q      <= 4'd0;
            bad_q       <= 4'd0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (valid_in),
        .clr   (clr_cnt),
        .count (word_count)
    );

    // Counts in the same cycle the pulse is registered, so err_count and
    // err_pulse update together.
    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (err_pulse_d),
        .clr   (clr_cnt),
        .count (err_count)
    );

endmodule

// File: tb/tb_traffic_checker.sv
module tb_traffic_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        clr_cnt = 1'b0;

    logic        locked, err_pulse;
    logic [15:0] word_count, err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  word_count4, err_count4;

    always #5 clk = ~clk;

    traffic_checker dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .word_count(word_count), .err_count(err_count)
    );

    // Narrow-counter variant for saturation checks, same stimulus.
    traffic_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .clr_cnt(clr_cnt), .locked(locked4), .err_pulse(err_pulse4),
        .word_count(word_count4), .err_count(err_count4)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        locked;
        logic        err;
        logic [15:0] wc, ec;
        logic [3:0]  wc4, ec4;
    } exp_t;

    exp_t sb[$];

    int          m_state;   // 0 hunt, 1 sync, 2 locked
    logic [7:0]  m_ref;
    int          m_good, m_bad;
    logic [15:0] m_wc, m_ec;
    logic [3:0]  m_wc4, m_ec4;

    function automatic logic [7:0] succ(input logic [7:0] r);
        return {r[6:0], ~(r[7] ^ r[3] ^ r[2] ^ r[1])};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ref = 8'h00; m_good = 0; m_bad = 0;
        m_wc = 0; m_ec = 0; m_wc4 = 0; m_ec4 = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c, output exp_t e);
        logic err;
        logic mt;
        err = 1'b0;
        if (v) begin
            mt = (d == succ(m_ref)) && (d != 8'hFF);
            if (m_state == 0) begin
                if (d != 8'hFF) begin m_ref = d; m_good = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (mt) begin
                    m_ref = d; m_good++;
                    if (m_good == 4) begin m_state = 2; m_bad = 0; end
                end else if (d != 8'hFF) begin
                    m_ref = d; m_good = 0;
                end else m_state = 0;
            end else begin
                m_ref = d;
                if (mt) m_bad = 0;
                else begin
                    err = 1'b1; m_bad++;
                    if (m_bad == 4) begin m_state = (d == 8'hFF) ? 0 : 1; m_good = 0; end
                end
            end
        end
        if (c) begin m_wc = 0; m_ec = 0; m_wc4 = 0; m_ec4 = 0; end
        else begin
            if (v && m_wc != 16'hFFFF) m_wc++;
            if (v && m_wc4 != 4'hF) m_wc4++;
            if (err && m_ec != 16'hFFFF) m_ec++;
            if (err && m_ec4 != 4'hF) m_ec4++;
        end
        e.locked = (m_state == 2);
        e.err = err;
        e.wc = m_wc; e.ec = m_ec; e.wc4 = m_wc4; e.ec4 = m_ec4;
    endtask

    // Drive one cycle; expectation pushed at drive, popped and compared after the edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        valid_in = v; data_in = d; clr_cnt = c;
        model_step(v, d, c, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_locked", {31'd0, locked}, {31'd0, e.locked});
        chk("sb_err", {31'd0, err_pulse}, {31'd0, e.err});
        chk("sb_wc", {16'd0, word_count}, {16'd0, e.wc});
        chk("sb_ec", {16'd0, err_count}, {16'd0, e.ec});
        chk("sb_wc4", {28'd0, word_count4}, {28'd0, e.wc4});
        chk("sb_ec4", {28'd0, err_count4}, {28'd0, e.ec4});
        chk("sb_locked4", {31'd0, locked4}, {31'd0, e.locked});
        @(negedge clk);
        valid_in = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [7:0] clean [9] = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0D, 8'h1B, 8'h37, 8'h6F, 8'hDE};
    logic [7:0] corr  [9] = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0D, 8'h1B, 8'h55, 8'h6F, 8'hDE};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur, w;
        model_reset();
        #12;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err", {31'd0, err_pulse}, 32'd0);
        chk("rst_wc", {16'd0, word_count}, 32'd0);
        chk("rst_ec", {16'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Clean back-to-back stream.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, clean[i], 1'b0);
            if (i == 3) chk("clean_prelock", {31'd0, locked}, 32'd0);
            if (i == 4) chk("clean_lockpt", {31'd0, locked}, 32'd1);
        end
        chk("clean_wc", {16'd0, word_count}, 32'd9);
        chk("clean_ec", {16'd0, err_count}, 32'd0);

        // Same stream with idle gaps of 0..5 cycles.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < i % 6; g++) drive(1'b0, 8'h5A, 1'b0);
            drive(1'b1, clean[i], 1'b0);
            if (i == 3) chk("gap_prelock", {31'd0, locked}, 32'd0);
            if (i == 4) chk("gap_lockpt", {31'd0, locked}, 32'd1);
        end
        chk("gap_wc", {16'd0, word_count}, 32'd9);
        chk("gap_ec", {16'd0, err_count}, 32'd0);

        // Single corrupted word costs two errors, lock held.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, corr[i], 1'b0);
            if (i == 6 || i == 7) chk("corr_pulse", {31'd0, err_pulse}, 32'd1);
            if (i == 8) chk("corr_nopulse", {31'd0, err_pulse}, 32'd0);
        end
        chk("corr_ec", {16'd0, err_count}, 32'd2);
        chk("corr_locked", {31'd0, locked}, 32'd1);

        // Four wrong words: bad_cnt was cleared on DE so lock holds through 3.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hAA, 1'b0);
            chk("unlk_pulse", {31'd0, err_pulse}, 32'd1);
            chk("unlk_locked", {31'd0, locked}, (i < 3) ? 32'd1 : 32'd0);
        end
        chk("unlk_ec", {16'd0, err_count}, 32'd6);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'h13, 1'b0);
        chk("unlk_ec_hold", {16'd0, err_count}, 32'd6);

        // 0xFF in HUNT is ignored but counted; in SYNC it drops to HUNT.
        do_reset();
        drive(1'b1, 8'hFF, 1'b0);
        chk("ff_hunt_wc", {16'd0, word_count}, 32'd1);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b1, 8'h06, 1'b0);
        drive(1'b1, 8'h0D, 1'b0);
        chk("ff_sync_hunt", {31'd0, locked}, 32'd0);
        drive(1'b1, 8'h1B, 1'b0);
        drive(1'b1, 8'h37, 1'b0);
        drive(1'b1, 8'h6F, 1'b0);
        chk("ff_relock", {31'd0, locked}, 32'd1);
        chk("ff_wc", {16'd0, word_count}, 32'd10);

        // Saturation: one error per wrong/right pair while locked.
        cur = 8'h6F;
        for (int i = 0; i < 20; i++) begin
            w = succ(cur) ^ 8'h01;
            if (w == 8'hFF) w = w ^ 8'h02;
            drive(1'b1, w, 1'b0);
            cur = succ(w);
            drive(1'b1, cur, 1'b0);
        end
        chk("sat_ec4", {28'd0, err_count4}, 32'hF);
        chk("sat_wc4", {28'd0, word_count4}, 32'hF);
        chk("sat_ec16", {16'd0, err_count}, 32'd20);
        chk("sat_locked", {31'd0, locked}, 32'd1);

        // Clear wins over a same-cycle error.
        drive(1'b1, succ(cur) ^ 8'h10, 1'b1);
        chk("clr_pulse", {31'd0, err_pulse}, 32'd1);
        chk("clr_ec", {16'd0, err_count}, 32'd0);
        chk("clr_wc", {16'd0, word_count}, 32'd0);
        chk("clr_locked", {31'd0, locked}, 32'd1);

        // Async reset mid-lock, checked before any clock edge.
        drive(1'b1, 8'h22, 1'b0);
        chk("pre_rst_ec", {16'd0, err_count}, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_err", {31'd0, err_pulse}, 32'd0);
        chk("arst_wc", {16'd0, word_count}, 32'd0);
        chk("arst_ec", {16'd0, err_count}, 32'd0);
        model_reset();
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        // Re-acquisition takes 1 + LOCK_CNT words.
        for (int i = 0; i < 5; i++) drive(1'b1, clean[i + 2], 1'b0);
        chk("reacq_locked", {31'd0, locked}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_checker.md
# traffic_checker

Receive-side companion of the 8-bit LFSR traffic generator used on router injection ports. It sits on a router ejection port, self-synchronises to the incoming pseudo-random byte stream, and confirms it. Each sampled byte must equal the generator's successor of the previously sampled byte. It reports lock status, per-word error pulses and saturating word/error counters for NoC testbench and on-chip traffic checks.

## Interface
- LOCK_CNT, 4: consecutive correct predictions needed to declare lock (1..15)
- UNLOCK_CNT, 4: consecutive mispredictions while locked that drop lock (1..15)
- CNT_W, 16: width of word and error counters
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  8  received traffic byte
- valid_in  in  1  data_in is sampled on this edge; no backpressure, always accepted
- clr_cnt  in  1  synchronous clear of word_count/err_count; FSM unaffected
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle pulse per mispredicted word while LOCKED
- word_count  out  CNT_W  valid words received, saturating
- err_count  out  CNT_W  mispredicted words while LOCKED, saturating

## Operation
- Successor function: nxt(x) = {x[6:0], ~(x[7]^x[3]^x[2]^x[1])}.
- 0xFF is the XNOR lockup value and is never a legal word.
- Internal regs:
  - ref[7:0]: last sampled byte
  - good_cnt, bad_cnt: 4 bits each
  - state: HUNT / SYNC / LOCKED
- A word matches when valid_in=1, data_in==nxt(ref) and data_in!=0xFF.
- HUNT: on a valid word other than 0xFF, load ref, good_cnt=0, go to SYNC. A valid 0xFF is ignored.
- SYNC: on a valid word:
  - match: good_cnt++. If good_cnt reaches LOCK_CNT, go to LOCKED with bad_cnt=0.
  - mismatch, not 0xFF: reseed ref, good_cnt=0, stay in SYNC.
  - 0xFF: go to HUNT.
  - No errors are counted in SYNC.
- LOCKED: on a valid word:
  - ref always reloads from data_in, so a single corrupted word costs at most two errors.
  - match: bad_cnt=0.
  - mismatch: err_pulse, err_count+1, bad_cnt++. If bad_cnt reaches UNLOCK_CNT, go to SYNC with good_cnt=0 and ref=data_in (HUNT if data_in=0xFF).
- word_count increments on every valid word, in every state.
- Counters saturate at all-ones.
- clr_cnt has priority over a same-cycle increment; the result is 0.
- Idle cycles (valid_in=0) change nothing. Gaps of any length are legal.

## Timing
- All outputs are registered. Response latency is one cycle: a word sampled at edge N gives locked, err_pulse and counter values visible after edge N.
- locked rises after the edge that samples the LOCK_CNT-th consecutive match.
- locked falls after the edge that samples the UNLOCK_CNT-th consecutive mismatch.
- err_pulse is high for exactly one cycle per erroneous word. Back-to-back errors give a continuous high.
- Reset (async assert, sync deassert from the system) returns:
  - state = HUNT, ref = 0x00, good_cnt = bad_cnt = 0
  - locked = 0, err_pulse = 0, word_count = 0, err_count = 0
- Reset mid-stream discards lock. Re-acquisition needs 1 + LOCK_CNT valid words.

## Structure
- Package traffic_pkg holds:
  - LFSR taps constant (7,3,2,1)
  - LFSR_LOCKUP = 8'hFF
  - state enum {HUNT, SYNC, LOCKED}
  - function lfsr8_next(x), shared with the generator so that both ends use one definition
- One sub-module is natural: sat_counter (CNT_W, inc, clr, saturating), instanced twice for word_count and err_count.

## Test plan
- Clean stream, one word per cycle, starting from reset value: 00,01,03,06,0D,1B,37,6F,DE.
  - Required: locked rises after 0D is sampled; err_count = 0; word_count = 9.
- Same stream with valid_in gaps of 0..5 cycles between words.
  - Required: identical lock point and counts.
- Locked, then inject 0x55 in place of 0x37 (sequence 1B,55,6F).
  - Required: err_pulse on 55 and on 6F, err_count = 2, locked stays 1, bad_cnt clears on DE.
- Locked, then apply four consecutive wrong words (e.g. AA,AA,AA,AA).
  - Required: four pulses, err_count = 4; locked falls after the 4th; no further err_count increments until re-lock.
- valid_in=1 with data_in=0xFF in HUNT and in SYNC.
  - Required: state stays in HUNT / returns to HUNT, locked = 0; word_count still increments.
- Preload err_count to 16'hFFFF via forced errors (reduce CNT_W=4 in a variant), then one more error.
  - Required: counter holds all-ones.
  - Assert clr_cnt together with an error: count = 0.
  - Async reset pulse mid-lock: all outputs 0 immediately.
